// File: rtl/mandel_lane_scheduler.sv
// Raster-order coordinate generator that fans pixels out round-robin to NUM_ENGINES
// depth engines and retires their out-of-order results back in raster order.
module mandel_lane_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int DEPTH_W     = 10
) (
  input  logic                             out_stream_aclk,
  input  logic                             periph_resetn,
  input  logic                             frame_en,
  input  logic [WORD_LENGTH-1:0]           real_start,
  input  logic [WORD_LENGTH-1:0]           imag_start,
  input  logic [WORD_LENGTH-1:0]           step,
  output logic [NUM_ENGINES-1:0]           eng_start,
  output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_re_c,
  output logic [NUM_ENGINES*WORD_LENGTH-1:0] eng_im_c,
  input  logic [NUM_ENGINES-1:0]           eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0]   eng_depth,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [DEPTH_W-1:0]               pix_depth,
  output logic [9:0]                       pix_x,
  output logic [8:0]                       pix_y,
  output logic                             pix_sof,
  output logic                             pix_eol,
  output logic                             frame_done,
  output logic [15:0]                      frame_count,
  output logic                             err_spurious
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_ENGINES - 1);
  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                                  state_q, state_d;
  logic [WORD_LENGTH-1:0]                  real_q, real_d;
  logic [WORD_LENGTH-1:0]                  step_q, step_d;
  logic [WORD_LENGTH-1:0]                  re_acc_q, re_acc_d;
  logic [WORD_LENGTH-1:0]                  im_acc_q, im_acc_d;
  logic [9:0]                              disp_x_q, disp_x_d;
  logic [8:0]                              disp_y_q, disp_y_d;
  logic [9:0]                              ret_x_q, ret_x_d;
  logic [8:0]                              ret_y_q, ret_y_d;
  logic [PTR_W-1:0]                        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                        rd_ptr_q, rd_ptr_d;
  logic [NUM_ENGINES-1:0]                  busy_q, busy_d;
  logic [NUM_ENGINES-1:0]                  slot_valid_q, slot_valid_d;
  logic [NUM_ENGINES-1:0][DEPTH_W-1:0]     slot_depth_q, slot_depth_d;
  logic [NUM_ENGINES-1:0][WORD_LENGTH-1:0] lane_re_q, lane_re_d;
  logic [NUM_ENGINES-1:0][WORD_LENGTH-1:0] lane_im_q, lane_im_d;
  logic                                    frame_done_q, frame_done_d;
  logic [15:0]                             frame_count_q, frame_count_d;
  logic                                    err_q, err_d;

  logic accept;
  logic last_retire;

  assign accept      = slot_valid_q[rd_ptr_q] && pix_ready;
  assign last_retire = accept && (ret_x_q == X_LAST) && (ret_y_q == Y_LAST);

  always_comb begin
    state_d       = state_q;
    real_d        = real_q;
    step_d        = step_q;
    re_acc_d      = re_acc_q;
    im_acc_d      = im_acc_q;
    disp_x_d      = disp_x_q;
    disp_y_d      = disp_y_q;
    ret_x_d       = ret_x_q;
    ret_y_d       = ret_y_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    busy_d        = busy_q;
    slot_valid_d  = slot_valid_q;
    slot_depth_d  = slot_depth_q;
    lane_re_d     = lane_re_q;
    lane_im_d     = lane_im_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_d         = err_q;
    eng_start     = '0;

    case (state_q)
      IDLE: begin
        if (frame_en) begin
          real_d   = real_start;
          step_d   = step;
          re_acc_d = real_start;
          im_acc_d = imag_start;
          disp_x_d = '0;
          disp_y_d = '0;
          ret_x_d  = '0;
          ret_y_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // A lane is reusable only once its previous result has been retired.
        if (!busy_q[wr_ptr_q] && !slot_valid_q[wr_ptr_q]) begin
          eng_start[wr_ptr_q] = 1'b1;
          lane_re_d[wr_ptr_q] = re_acc_q;
          lane_im_d[wr_ptr_q] = im_acc_q;
          busy_d[wr_ptr_q]    = 1'b1;
          wr_ptr_d            = (wr_ptr_q == LAST_LANE) ? '0 : wr_ptr_q + 1'b1;
          if (disp_x_q == X_LAST) begin
            disp_x_d = '0;
            disp_y_d = disp_y_q + 1'b1;
            re_acc_d = real_q;
            im_acc_d = im_acc_q - step_q;
            if (disp_y_q == Y_LAST) begin
              disp_y_d = '0;
              state_d  = DRAIN;
            end
          end else begin
            disp_x_d = disp_x_q + 1'b1;
            re_acc_d = re_acc_q + step_q;
          end
        end
      end
      DRAIN: begin
        if (last_retire) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (eng_done[k]) begin
        if (busy_q[k]) begin
          busy_d[k]       = 1'b0;
          slot_valid_d[k] = 1'b1;
          slot_depth_d[k] = eng_depth[k*DEPTH_W +: DEPTH_W];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (accept) begin
      slot_valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d               = (rd_ptr_q == LAST_LANE) ? '0 : rd_ptr_q + 1'b1;
      if (ret_x_q == X_LAST) begin
        ret_x_d = '0;
        ret_y_d = (ret_y_q == Y_LAST) ? '0 : ret_y_q + 1'b1;
      end else begin
        ret_x_d = ret_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q       <= IDLE;
      real_q        <= '0;
      step_q        <= '0;
      re_acc_q      <= '0;
      im_acc_q      <= '0;
      disp_x_q      <= '0;
      disp_y_q      <= '0;
      ret_x_q       <= '0;
      ret_y_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      busy_q        <= '0;
      slot_valid_q  <= '0;
      slot_depth_q  <= '0;
      lane_re_q     <= '0;
      lane_im_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      real_q        <= real_d;
      step_q        <= step_d;
      re_acc_q      <= re_acc_d;
      im_acc_q      <= im_acc_d;
      disp_x_q      <= disp_x_d;
      disp_y_q      <= disp_y_d;
      ret_x_q       <= ret_x_d;
      ret_y_q       <= ret_y_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      busy_q        <= busy_d;
      slot_valid_q  <= slot_valid_d;
      slot_depth_q  <= slot_depth_d;
      lane_re_q     <= lane_re_d;
      lane_im_q     <= lane_im_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  // The _d view carries the freshly dispatched c so it is valid alongside its start pulse.
  assign eng_re_c     = lane_re_d;
  assign eng_im_c     = lane_im_d;
  assign pix_valid    = slot_valid_q[rd_ptr_q];
  assign pix_depth    = slot_depth_q[rd_ptr_q];
  assign pix_x        = ret_x_q;
  assign pix_y        = ret_y_q;
  assign pix_sof      = pix_valid && (ret_x_q == '0) && (ret_y_q == '0);
  assign pix_eol      = pix_valid && (ret_x_q == X_LAST);
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign err_spurious = err_q;

endmodule
